// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
// Arbitrates the single register-file write port between the pipeline
// writeback (EX), a one-entry buffer holding divider results, and an
// optional debug register access path.
//
// EX writes go through in the same cycle. A divider result is written
// when EX leaves the port idle. If EX keeps the port busy for
// STARVE_LIMIT cycles while a result waits in the buffer, the pipeline
// is stalled for one cycle and the buffered result is written.
//
// Optional feature: define RF_DBG_EN to build the debug path (states
// DBG_WAIT/DBG_ACC/DBG_DONE and the read-address override). Without it
// the debug ports stay on the module but are ignored.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   ex_we_i/ex_waddr_i/ex_wdata_i    writeback request from the pipeline
//   div_valid_i/div_waddr_i/
//   div_wdata_i, div_ready_o         divider result handshake
//   dbg_req_i/dbg_we_i/dbg_addr_i/
//   dbg_wdata_i, dbg_ack_o,
//   dbg_rdata_o                      debug register access
//   id_rd2_addr_i, rf_rd2_addr_o,
//   rf_rd2_data_i                    read port 2 address mux and data
//   rf_we_o/rf_waddr_o/rf_wdata_o    register file write port
//   hold_pipe_o                      pipeline stall, writeback re-presented
module rf_wr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        div_valid_i,
  input  logic [4:0]  div_waddr_i,
  input  logic [31:0] div_wdata_i,
  output logic        div_ready_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_rdata_o,
  input  logic [4:0]  id_rd2_addr_i,
  input  logic [31:0] rf_rd2_data_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [4:0]  rf_rd2_addr_o,
  output logic        hold_pipe_o
);

  typedef enum logic [2:0] {
    IDLE, DIV_FORCE, DBG_WAIT, DBG_ACC, DBG_DONE
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        buf_valid_q;
  logic [4:0]  buf_addr_q;
  logic [31:0] buf_data_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        drain;
  logic        rdata_ld;

  assign div_ready_o = ~buf_valid_q;
  assign hold_pipe_o = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain         = 1'b0;
    rdata_ld      = 1'b0;
    rf_we_o       = 1'b0;
    rf_waddr_o    = 5'd0;
    rf_wdata_o    = 32'd0;
    rf_rd2_addr_o = id_rd2_addr_i;
    case (state_q)
      IDLE: begin
        if (ex_we_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = ex_waddr_i;
          rf_wdata_o = ex_wdata_i;
        end else if (buf_valid_q) begin
          drain = 1'b1;
        end
        // Count only cycles where a waiting result loses to EX; the
        // stall is taken on the edge where the count reaches the limit,
        // so exactly STARVE_LIMIT EX writes overtake the buffer.
        if (buf_valid_q && ex_we_i) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == LIMIT) state_d = DIV_FORCE;
`ifdef RF_DBG_EN
          else if (dbg_req_i) state_d = DBG_WAIT;
`endif
        end else begin
          cnt_d = 4'd0;
`ifdef RF_DBG_EN
          if (dbg_req_i) state_d = DBG_WAIT;
`endif
        end
      end
      DIV_FORCE: begin
        drain   = buf_valid_q;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
`ifdef RF_DBG_EN
      DBG_WAIT: begin
        drain   = buf_valid_q;
        state_d = DBG_ACC;
      end
      DBG_ACC: begin
        // Writes to x0 are forwarded; the register file discards them.
        if (dbg_we_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = dbg_addr_i;
          rf_wdata_o = dbg_wdata_i;
        end else begin
          rf_rd2_addr_o = dbg_addr_i;
          rdata_ld      = 1'b1;
        end
        state_d = DBG_DONE;
      end
      DBG_DONE: begin
        drain = buf_valid_q;
        if (!dbg_req_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (drain) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = buf_addr_q;
      rf_wdata_o = buf_data_q;
    end
    // Outside IDLE the counter only holds while the buffer is blocked.
    if (state_q != IDLE && (drain || !buf_valid_q)) cnt_d = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= 5'd0;
      buf_data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // drain only happens with the buffer full, acceptance only with it
      // empty, so the two never collide.
      if (drain) begin
        buf_valid_q <= 1'b0;
      end else if (div_valid_i && !buf_valid_q) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= div_waddr_i;
        buf_data_q  <= div_wdata_i;
      end
    end
  end

`ifdef RF_DBG_EN
  assign dbg_ack_o = (state_q == DBG_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        dbg_rdata_o <= 32'd0;
    else if (rdata_ld) dbg_rdata_o <= rf_rd2_data_i;
  end
`else
  assign dbg_ack_o   = 1'b0;
  assign dbg_rdata_o = 32'd0;

  logic unused_dbg;
  assign unused_dbg = ^{dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
                        rf_rd2_data_i, rdata_ld};
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_rf_wr_arbiter;

`ifdef RF_DBG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        div_valid_i;
  logic [4:0]  div_waddr_i;
  logic [31:0] div_wdata_i;
  logic        div_ready_o;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_rdata_o;
  logic [4:0]  id_rd2_addr_i;
  logic [31:0] rf_rd2_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  rf_rd2_addr_o;
  logic        hold_pipe_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Register file read model: register n holds 0xCAFE0000 | n.
  assign rf_rd2_data_i = {16'hCAFE, 11'd0, rf_rd2_addr_o};

  rf_wr_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .div_valid_i(div_valid_i), .div_waddr_i(div_waddr_i),
    .div_wdata_i(div_wdata_i), .div_ready_o(div_ready_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o),
    .dbg_rdata_o(dbg_rdata_o), .id_rd2_addr_i(id_rd2_addr_i),
    .rf_rd2_data_i(rf_rd2_data_i), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_rd2_addr_o(rf_rd2_addr_o), .hold_pipe_o(hold_pipe_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input string tag, input logic we, input logic [4:0] a,
                    input logic [31:0] d);
    chk({tag, ".we"}, 32'(rf_we_o), 32'(we));
    chk({tag, ".addr"}, 32'(rf_waddr_o), 32'(a));
    chk({tag, ".data"}, rf_wdata_o, d);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    div_valid_i = 0; div_waddr_i = 0; div_wdata_i = 0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    id_rd2_addr_i = 5'd20;

    // Reset state
    smp();
    wr("rst", 0, 0, 0);
    chk("rst.hold", 32'(hold_pipe_o), 0);
    chk("rst.ack", 32'(dbg_ack_o), 0);
    chk("rst.rdata", dbg_rdata_o, 0);
    adv();
    rst_n = 1'b1;
    smp();
    chk("rst.ready", 32'(div_ready_o), 1);
    chk("rst.rd2", 32'(rf_rd2_addr_o), 20);

    // EX only: zero latency pass-through
    adv();
    ex_we_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'h1234;
    smp();
    wr("ex", 1, 5, 32'h1234);
    chk("ex.hold", 32'(hold_pipe_o), 0);
    adv();
    ex_we_i = 0;
    smp();
    wr("ex_off", 0, 0, 0);

    // DIV with EX idle: accepted cycle 0, written cycle 1
    adv();
    div_valid_i = 1; div_waddr_i = 7; div_wdata_i = 32'hDEAD;
    smp();
    chk("div.c0.ready", 32'(div_ready_o), 1);
    wr("div.c0", 0, 0, 0);
    adv();
    div_valid_i = 0;
    smp();
    chk("div.c1.ready", 32'(div_ready_o), 0);
    wr("div.c1", 1, 7, 32'hDEAD);
    adv();
    smp();
    chk("div.c2.ready", 32'(div_ready_o), 1);
    wr("div.c2", 0, 0, 0);

    // Starvation: buffered result loses 4 times, then forced write
    adv();
    div_valid_i = 1; div_waddr_i = 10; div_wdata_i = 32'hBEEF;
    ex_we_i = 1; ex_waddr_i = 1; ex_wdata_i = 32'h100;
    smp();
    wr("stv.c0", 1, 1, 32'h100);
    for (int i = 1; i <= 4; i++) begin
      adv();
      div_valid_i = 0;
      ex_waddr_i = 5'(i + 1); ex_wdata_i = 32'h100 + 32'(i);
      smp();
      wr($sformatf("stv.c%0d", i), 1, 5'(i + 1), 32'h100 + 32'(i));
      chk($sformatf("stv.c%0d.hold", i), 32'(hold_pipe_o), 0);
    end
    adv();
    ex_waddr_i = 5'd30; ex_wdata_i = 32'h777;
    smp();
    chk("stv.force.hold", 32'(hold_pipe_o), 1);
    wr("stv.force", 1, 10, 32'hBEEF);
    adv();
    smp();
    chk("stv.resume.hold", 32'(hold_pipe_o), 0);
    chk("stv.resume.ready", 32'(div_ready_o), 1);
    wr("stv.resume", 1, 30, 32'h777);
    adv();
    ex_we_i = 0;

    // Debug read of x3
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 3;
    smp();
    chk("dr.c0.hold", 32'(hold_pipe_o), 0);
    chk("dr.c0.rd2", 32'(rf_rd2_addr_o), 20);
    adv();
    smp();
    chk("dr.c1.hold", 32'(hold_pipe_o), 32'(DBG));
    chk("dr.c1.ack", 32'(dbg_ack_o), 0);
    adv();
    smp();
    chk("dr.c2.rd2", 32'(rf_rd2_addr_o), DBG ? 32'd3 : 32'd20);
    wr("dr.c2", 0, 0, 0);
    adv();
    smp();
    chk("dr.c3.ack", 32'(dbg_ack_o), 32'(DBG));
    chk("dr.c3.rdata", dbg_rdata_o, DBG ? 32'hCAFE0003 : 32'd0);
    chk("dr.c3.rd2", 32'(rf_rd2_addr_o), 20);
    adv();
    dbg_req_i = 0;
    smp();
    chk("dr.c4.ack", 32'(dbg_ack_o), 32'(DBG));
    adv();
    smp();
    chk("dr.c5.hold", 32'(hold_pipe_o), 0);
    chk("dr.c5.ack", 32'(dbg_ack_o), 0);

    // Request dropped before ack: access still completes, one ack cycle
    adv();
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 4;
    adv();
    dbg_req_i = 0;
    adv();
    adv();
    smp();
    chk("drop.ack", 32'(dbg_ack_o), 32'(DBG));
    chk("drop.rdata", dbg_rdata_o, DBG ? 32'hCAFE0004 : 32'd0);
    adv();
    smp();
    chk("drop.exit.hold", 32'(hold_pipe_o), 0);
    chk("drop.exit.ack", 32'(dbg_ack_o), 0);

    // Debug write x9 with a DIV result arriving at the same time
    adv();
    div_valid_i = 1; div_waddr_i = 12; div_wdata_i = 32'hD1;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 9; dbg_wdata_i = 32'h55;
    smp();
    wr("dw.c0", 0, 0, 0);
    adv();
    div_valid_i = 0;
    smp();
    wr("dw.c1.div", 1, 12, 32'hD1);
    adv();
    smp();
    if (DBG) wr("dw.c2.dbg", 1, 9, 32'h55);
    else     wr("dw.c2.dbg", 0, 0, 0);
    chk("dw.c2.hold", 32'(hold_pipe_o), 32'(DBG));
    // Asynchronous reset in the middle of the access
    #1;
    rst_n = 0;
    #1;
    wr("dw.rst", 0, 0, 0);
    chk("dw.rst.hold", 32'(hold_pipe_o), 0);
    chk("dw.rst.ack", 32'(dbg_ack_o), 0);
    chk("dw.rst.rdata", dbg_rdata_o, 0);
    chk("dw.rst.ready", 32'(div_ready_o), 1);
    dbg_req_i = 0; dbg_we_i = 0;
    adv();
    rst_n = 1;
    ex_we_i = 1; ex_waddr_i = 2; ex_wdata_i = 32'hABC;
    smp();
    chk("post.hold", 32'(hold_pipe_o), 0);
    wr("post.ex", 1, 2, 32'hABC);
    adv();
    ex_we_i = 0;
    smp();
    wr("post.idle", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, number of consecutive cycles a buffered DIV result may lose to EX (range 1..15).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ex_we_i / ex_waddr_i / ex_wdata_i  input  1/5/32  pipeline writeback request, address, data.
REQ-005 SHALL have port: div_valid_i / div_waddr_i / div_wdata_i  input  1/5/32  divider result offer.
REQ-006 SHALL have port: div_ready_o  output  1  divider result accepted when div_valid_i & div_ready_o.
REQ-007 SHALL have port: dbg_req_i / dbg_we_i / dbg_addr_i / dbg_wdata_i  input  1/1/5/32  debug register access request.
REQ-008 SHALL have port: dbg_ack_o / dbg_rdata_o  output  1/32  debug completion and read data.
REQ-009 SHALL have port: id_rd2_addr_i  input  5  decode-stage read-port-2 address.
REQ-010 SHALL have port: rf_rd2_data_i  input  32  register file read-port-2 data.
REQ-011 SHALL have port: rf_we_o / rf_waddr_o / rf_wdata_o  output  1/5/32  register file write port.
REQ-012 SHALL have port: rf_rd2_addr_o  output  5  register file read-port-2 address.
REQ-013 SHALL have port: hold_pipe_o  output  1  stalls pipeline; writeback stage held and re-presented.

Function
REQ-014 SHALL hold one DIV entry (buf_valid, addr, data); div_ready_o = ~buf_valid; accepted entry is written no earlier than the next cycle.
REQ-015 SHALL use states IDLE, DIV_FORCE, DBG_WAIT, DBG_ACC, DBG_DONE; hold_pipe_o = 1 in every state except IDLE.
REQ-016 IDLE: ex_we_i=1 SHALL pass EX to write port same cycle (0 latency); else buf_valid=1 SHALL write buffer and clear buf_valid.
REQ-017 IDLE: starve counter SHALL increment each cycle buf_valid & ex_we_i, and clear when buffer drains or buf_valid=0.
REQ-018 IDLE: counter == STARVE_LIMIT SHALL transition to DIV_FORCE; DIV_FORCE writes buffer, clears counter, returns to IDLE next cycle.
REQ-019 IDLE: dbg_req_i=1 and no DIV_FORCE condition SHALL transition to DBG_WAIT; DIV_FORCE has priority over debug.
REQ-020 While hold_pipe_o=1, ex_we_i SHALL be ignored (no EX write issued).
REQ-021 DBG_WAIT: one cycle, buffered DIV MAY drain; next state DBG_ACC.
REQ-022 DBG_ACC: dbg_we_i=1 writes dbg_wdata_i to dbg_addr_i (x0 forwarded, RF discards); dbg_we_i=0 drives rf_rd2_addr_o=dbg_addr_i and registers rf_rd2_data_i into dbg_rdata_o; DIV drain blocked; next DBG_DONE.
REQ-023 DBG_DONE: dbg_ack_o=1; buffered DIV MAY drain; remain until dbg_req_i=0, then IDLE.
REQ-024 dbg_req_i dropped before ack SHALL still complete the access; DBG_DONE then exits after one cycle.
REQ-025 rf_rd2_addr_o SHALL equal id_rd2_addr_i in all states except DBG_ACC read.
REQ-026 At most one write SHALL be issued per cycle; rf_waddr_o/rf_wdata_o are 0 when rf_we_o=0.
REQ-027 DIV result SHALL never be dropped or duplicated; DIV acceptance allowed in any state when buf_valid=0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, buf_valid 0, counter 0, dbg_rdata_o 0, dbg_ack_o 0, hold_pipe_o 0, rf_we_o 0, div_ready_o 1 after release; mid-operation reset discards buffered entry and any debug access.

Configuration
REQ-029 With RF_DBG_EN defined, the debug path (DBG_WAIT/DBG_ACC/DBG_DONE, read-address override) SHALL be present as above.
REQ-030 Without RF_DBG_EN, debug ports SHALL remain but be ignored: dbg_ack_o=0, dbg_rdata_o=0, rf_rd2_addr_o=id_rd2_addr_i, dbg_req_i never leaves IDLE.

Verification
REQ-031 EX only: ex_we_i=1, addr 5, data 0x1234 -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234 same cycle, hold_pipe_o=0.
REQ-032 DIV with EX idle: div offer addr 7, data 0xDEAD at cycle 0 -> div_ready_o=0 cycle 1, RF write addr 7 cycle 1, div_ready_o=1 cycle 2.
REQ-033 Starvation: DIV buffered, ex_we_i=1 continuously, STARVE_LIMIT=4 -> 4 EX writes, then DIV_FORCE cycle: hold_pipe_o=1, DIV written, EX ignored, then EX resumes.
REQ-034 Debug read: x3=0xCAFE0003, dbg_req_i=1, dbg_we_i=0, addr 3 -> hold_pipe_o from next cycle, dbg_ack_o=1 two cycles later, dbg_rdata_o=0xCAFE0003, IDLE one cycle after req drops.
REQ-035 Debug write x9=0x55 while DIV buffered -> DIV drains in DBG_WAIT, debug write in DBG_ACC, no lost write; rst_n pulse in DBG_ACC -> all outputs 0, state IDLE.
